// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexes one shared BCD-to-7-segment decoder across DIGITS digits.
// Optional build macro LEADING_ZERO_BLANK_EN keeps anodes dark for leading-zero digits.
module seg_scan_controller #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                load,
  output logic                load_ack,
  output logic [3:0]          num,
  input  logic [6:0]          seg_in,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int PMAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [PW-1:0] DRIVE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [0:0]          state_r, state_s;
  logic [PW-1:0]       phase_r, phase_s;
  logic [DW-1:0]       digit_r, digit_s;
  logic                wrap_s;
  logic [4*DIGITS-1:0] shadow_r, shadow_s;
  logic [4*DIGITS-1:0] pend_data_r, pend_data_s;
  logic                pend_r, pend_s, pend_hit_s;
  logic                ack_s;
  logic                drive_s;
  logic                frame_end_s;
  logic [3:0]          num_r, num_s;
  logic [6:0]          seg_r, seg_s;
  logic [DIGITS-1:0]   an_r, an_s;
  logic                load_ack_r;
  logic                frame_done_r;

  function automatic logic [3:0] digit_code(input logic [4*DIGITS-1:0] vec,
                                            input logic [DW-1:0] d);
    logic [3:0] code;
    code = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (DW'(k) == d) code = vec[4*k +: 4];
      else             code = code;
    end
    return code;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // True when digit d and every more significant digit hold zero (digit 0 never qualifies).
  function automatic logic leading_zero(input logic [4*DIGITS-1:0] vec,
                                        input logic [DW-1:0] d);
    logic nonzero;
    nonzero = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((DW'(k) >= d) && (vec[4*k +: 4] != 4'd0)) nonzero = 1'b1;
      else                                          nonzero = nonzero;
    end
    return (d != {DW{1'b0}}) && !nonzero;
  endfunction
`endif

  // Slot sequencing: BLANK then DRIVE per digit, digit index advancing after each DRIVE.
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    digit_s = digit_r;
    wrap_s  = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (phase_r == BLANK_LAST) begin
          state_s = ST_DRIVE;
          phase_s = {PW{1'b0}};
        end else begin
          phase_s = phase_r + PW'(1);
        end
      end
      ST_DRIVE: begin
        if (phase_r == DRIVE_LAST) begin
          state_s = ST_BLANK;
          phase_s = {PW{1'b0}};
          if (digit_r == DIGIT_LAST) begin
            digit_s = {DW{1'b0}};
            wrap_s  = 1'b1;
          end else begin
            digit_s = digit_r + DW'(1);
          end
        end else begin
          phase_s = phase_r + PW'(1);
        end
      end
      default: begin
        state_s = ST_BLANK;
        phase_s = {PW{1'b0}};
        digit_s = {DW{1'b0}};
      end
    endcase
  end

  // Load handshake: a LOAD seen on the wrap edge itself still makes this boundary (last wins).
  always_comb begin
    pend_data_s = load ? bcd_in : pend_data_r;
    pend_hit_s  = load | pend_r;
    if (wrap_s && pend_hit_s) begin
      shadow_s = pend_data_s;
      ack_s    = 1'b1;
      pend_s   = 1'b0;
    end else begin
      shadow_s = shadow_r;
      ack_s    = 1'b0;
      pend_s   = pend_hit_s;
    end
  end

  // Output decode from the next-cycle state so every output is a register.
  always_comb begin
    num_s   = digit_code(shadow_s, digit_s);
    drive_s = (state_s == ST_DRIVE);
`ifdef LEADING_ZERO_BLANK_EN
    if (leading_zero(shadow_s, digit_s)) drive_s = 1'b0;
    else                                 drive_s = drive_s;
`endif
    an_s = {DIGITS{1'b1}};
    for (int k = 0; k < DIGITS; k++) begin
      an_s[k] = !(drive_s && (DW'(k) == digit_s));
    end
    frame_end_s = (state_s == ST_DRIVE) && (digit_s == DIGIT_LAST) && (phase_s == DRIVE_LAST);
    // SEG tracks the decoder only while blanked, so it is frozen before the anode turns on.
    seg_s = (state_r == ST_BLANK) ? seg_in : seg_r;
  end

  // Sequencer, shadow and pending registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_BLANK;
      phase_r     <= {PW{1'b0}};
      digit_r     <= {DW{1'b0}};
      shadow_r    <= {(4*DIGITS){1'b0}};
      pend_data_r <= {(4*DIGITS){1'b0}};
      pend_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      digit_r     <= digit_s;
      shadow_r    <= shadow_s;
      pend_data_r <= pend_data_s;
      pend_r      <= pend_s;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_r        <= 4'd0;
      seg_r        <= 7'd0;
      an_r         <= {DIGITS{1'b1}};
      load_ack_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      num_r        <= num_s;
      seg_r        <= seg_s;
      an_r         <= an_s;
      load_ack_r   <= ack_s;
      frame_done_r <= frame_end_s;
    end
  end

  assign num        = num_r;
  assign seg        = seg_r;
  assign an         = an_r;
  assign load_ack   = load_ack_r;
  assign frame_done = frame_done_r;

endmodule
